// File: rtl/fifo_pkg.sv
// Shared FIFO-side definitions: word width, serializer state encoding
// and default serial bit timing (TX_PARITY_EN adds the PARITY state).
package fifo_pkg;

    // Word width shared with the 32x8 FIFO (queue_fsm).
    localparam int WORD_LENGTH  = 8;

    // Default serial bit period in clk cycles and bit-timer width.
    localparam int CLKS_PER_BIT = 4;
    localparam int TIMER_WIDTH  = 16;

    // Serializer states. PARITY exists only when TX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_FETCH  = 3'd1,
        TX_WAIT   = 3'd2,
        TX_LOAD   = 3'd3,
        TX_START  = 3'd4,
        TX_DATA   = 3'd5,
`ifdef TX_PARITY_EN
        TX_STOP   = 3'd6,
        TX_PARITY = 3'd7
`else
        TX_STOP   = 3'd6
`endif
    } tx_state_t;

    // Width of an index able to address n items (at least 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // States whose duration is measured by the bit timer.
    function automatic logic is_timed(input tx_state_t s);
        logic t;
        t = 1'b0;
        unique case (s)
            TX_START,
            TX_DATA,
`ifdef TX_PARITY_EN
            TX_PARITY,
`endif
            TX_STOP:  t = 1'b1;
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/fifo_tx_serializer_bit_timer.sv
// Bit-period counter: counts 0..clks_per_bit-1, wraps on tick.
// Ports: clk, rst_n (async low), clear_i (sync clear), tick_o (last cycle).
module bit_timer #(
    parameter int timer_width  = 16,
    parameter int clks_per_bit = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam logic [timer_width-1:0] LAST = timer_width'(clks_per_bit - 1);

    logic [timer_width-1:0] count_q;
    logic [timer_width-1:0] count_d;

    assign tick_o = (count_q == LAST);

    // Wrapping on tick lets DATA run several bit periods in one state.
    always_comb begin
        count_d = count_q + timer_width'(1);
        if (clear_i || tick_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_tx_serializer.sv
// Drains words from the FIFO and sends each as a UART-style serial frame
// (start, data LSB first, optional even parity, stop). Optional macro:
// TX_PARITY_EN inserts the parity bit.
// Ports:
//   clk             rising-edge clock shared with the FIFO
//   reset           asynchronous active-low reset
//   enable          permits a new frame to start
//   stack_empty     FIFO empty flag
//   fifo_data       FIFO data_out
//   read_from_stack one-cycle FIFO read strobe
//   tx_serial       serial line, idles high
//   busy            high whenever not idle
//   tx_done         pulse in the last cycle of the stop bit
module fifo_tx_serializer
    import fifo_pkg::*;
#(
    parameter int word_length  = WORD_LENGTH,
    parameter int clks_per_bit = CLKS_PER_BIT,
    parameter int timer_width  = TIMER_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   stack_empty,
    input  logic [word_length-1:0] fifo_data,
    output logic                   read_from_stack,
    output logic                   tx_serial,
    output logic                   busy,
    output logic                   tx_done
);

    localparam int IW = idx_width(word_length);
    localparam logic [IW-1:0] LAST_IDX = IW'(word_length - 1);

    tx_state_t              state_q;
    tx_state_t              state_d;
    logic [word_length-1:0] shift_q;
    logic [word_length-1:0] shift_d;
    logic [IW-1:0]          idx_q;
    logic [IW-1:0]          idx_d;
`ifdef TX_PARITY_EN
    logic                   par_q;
    logic                   par_d;
`endif

    logic tick;
    logic tmr_clr;

    // Timer restarts on every state change and is held clear while
    // in the untimed states.
    assign tmr_clr = (state_d != state_q) || !is_timed(state_q);

    bit_timer #(
        .timer_width  (timer_width),
        .clks_per_bit (clks_per_bit)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (reset),
        .clear_i (tmr_clr),
        .tick_o  (tick)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= TX_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
`ifdef TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
`ifdef TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
`ifdef TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            TX_IDLE: begin
                if (enable && !stack_empty) begin
                    state_d = TX_FETCH;
                end
            end
            TX_FETCH: state_d = TX_WAIT;
            // FIFO presents the read word one edge after the strobe.
            TX_WAIT:  state_d = TX_LOAD;
            TX_LOAD: begin
                shift_d = fifo_data;
                idx_d   = '0;
`ifdef TX_PARITY_EN
                par_d   = ^fifo_data;
`endif
                state_d = TX_START;
            end
            TX_START: begin
                if (tick) begin
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
`ifdef TX_PARITY_EN
                        state_d = TX_PARITY;
`else
                        state_d = TX_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
`ifdef TX_PARITY_EN
            TX_PARITY: begin
                if (tick) begin
                    state_d = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (tick) begin
                    if (enable && !stack_empty) begin
                        state_d = TX_FETCH;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Moore outputs decoded from registered state, shift and timer.
    always_comb begin
        tx_serial       = 1'b1;
        read_from_stack = 1'b0;
        tx_done         = 1'b0;
        busy            = (state_q != TX_IDLE);
        unique case (state_q)
            TX_FETCH:  read_from_stack = 1'b1;
            TX_START:  tx_serial = 1'b0;
            TX_DATA:   tx_serial = shift_q[0];
`ifdef TX_PARITY_EN
            TX_PARITY: tx_serial = par_q;
`endif
            TX_STOP:   tx_done = tick;
            default:   tx_serial = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Testbench for fifo_tx_serializer with a behavioural FIFO and a
// serial-frame scoreboard.
module tb_fifo_tx_serializer;
    import fifo_pkg::*;

    localparam int WL  = 8;
    localparam int CPB = 4;
`ifdef TX_PARITY_EN
    localparam int NB  = WL + 3;
`else
    localparam int NB  = WL + 2;
`endif
    localparam int TOT = 3 + NB * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          stack_empty = 1'b1;
    logic [WL-1:0] fifo_data = '0;
    logic          read_from_stack;
    logic          tx_serial;
    logic          busy;
    logic          tx_done;

    logic          wr_en = 1'b0;
    logic [WL-1:0] wr_data = '0;

    logic [WL-1:0] fq[$];
    logic [WL-1:0] exp_q[$];

    int rd_cnt = 0;
    int rd_empty = 0;
    int assert_cnt = 0;
    int fail_cnt = 0;

    always #5 clk = ~clk;

    fifo_tx_serializer dut (
        .clk             (clk),
        .reset           (rst_n),
        .enable          (enable),
        .stack_empty     (stack_empty),
        .fifo_data       (fifo_data),
        .read_from_stack (read_from_stack),
        .tx_serial       (tx_serial),
        .busy            (busy),
        .tx_done         (tx_done)
    );

    // Behavioural FIFO: registered data_out and empty flag.
    always @(posedge clk) begin
        if (read_from_stack === 1'b1) begin
            rd_cnt <= rd_cnt + 1;
            if (stack_empty) rd_empty <= rd_empty + 1;
            if (fq.size() > 0) fifo_data <= fq.pop_front();
        end
        if (wr_en) fq.push_back(wr_data);
        stack_empty <= (fq.size() == 0);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic fifo_write(input logic [WL-1:0] w);
        wr_data = w;
        wr_en = 1'b1;
        exp_q.push_back(w);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Decodes one frame; good=0 on timeout or a malformed frame.
    task automatic rx_frame(input int max_wait, output logic [WL-1:0] w,
                            output logic par, output logic good,
                            output int gap);
        logic [NB-1:0] lvl;
        logic steady;
        int n;
        w = '0; par = 1'b0; good = 1'b0; gap = 0; steady = 1'b1;
        lvl = '0;
        n = 0;
        @(negedge clk);
        while (tx_serial !== 1'b0 && n < max_wait) begin
            gap++;
            n++;
            @(negedge clk);
        end
        if (tx_serial !== 1'b0) return;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (c == 0) lvl[b] = tx_serial;
                else if (tx_serial !== lvl[b]) steady = 1'b0;
            end
        end
        w = lvl[WL:1];
`ifdef TX_PARITY_EN
        par = lvl[WL+1];
`endif
        good = steady && (lvl[0] == 1'b0) && (lvl[NB-1] == 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        assert_cnt++;
        if (tx_serial !== 1'b1) begin
            $display("FAIL reset_tx: got %b want 1", tx_serial); fail_cnt++;
        end
        assert_cnt++;
        if (busy !== 1'b0) begin
            $display("FAIL reset_busy: got %b want 0", busy); fail_cnt++;
        end
        assert_cnt++;
        if (read_from_stack !== 1'b0) begin
            $display("FAIL reset_rd: got %b want 0", read_from_stack); fail_cnt++;
        end
        assert_cnt++;
        if (tx_done !== 1'b0) begin
            $display("FAIL reset_done: got %b want 0", tx_done); fail_cnt++;
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic [TOT-1:0] obs;
        logic [TOT-1:0] expv;
        logic [NB-1:0]  ef;
        logic [WL-1:0]  w;
        int done_n, done_cnt, rd0;
        done_n = 0; done_cnt = 0; rd0 = rd_cnt;
        obs = '0;
        enable = 1'b1;
        fifo_write(8'h01);
        for (int n = 1; n <= TOT + 4; n++) begin
            @(negedge clk);
            if (n <= TOT) obs[n-1] = tx_serial;
            if (tx_done === 1'b1) begin
                done_cnt++;
                if (done_n == 0) done_n = n;
            end
        end
        w = exp_q.pop_front();
        ef = '0;
        ef[0] = 1'b0;
        ef[WL:1] = w;
`ifdef TX_PARITY_EN
        ef[WL+1] = ^w;
`endif
        ef[NB-1] = 1'b1;
        expv = '0;
        for (int n = 1; n <= TOT; n++) begin
            if (n <= 3) expv[n-1] = 1'b1;
            else expv[n-1] = ef[(n-4)/CPB];
        end
        assert_cnt++;
        if (obs !== expv) begin
            $display("FAIL single_wave: got %b want %b", obs, expv); fail_cnt++;
        end
        assert_cnt++;
        if (done_n != TOT) begin
            $display("FAIL single_done_cycle: got %0d want %0d", done_n, TOT);
            fail_cnt++;
        end
        assert_cnt++;
        if (done_cnt != 1) begin
            $display("FAIL single_done_cnt: got %0d want 1", done_cnt); fail_cnt++;
        end
        assert_cnt++;
        if (rd_cnt - rd0 != 1) begin
            $display("FAIL single_reads: got %0d want 1", rd_cnt - rd0); fail_cnt++;
        end
        assert_cnt++;
        if (busy !== 1'b0) begin
            $display("FAIL single_idle: busy %b want 0", busy); fail_cnt++;
        end
        enable = 1'b0;
    endtask

    task automatic test_empty_idle();
        int rd0, lows, busys;
        rd0 = rd_cnt; lows = 0; busys = 0;
        enable = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (tx_serial !== 1'b1) lows++;
            if (busy !== 1'b0) busys++;
        end
        assert_cnt++;
        if (rd_cnt != rd0) begin
            $display("FAIL empty_reads: got %0d want 0", rd_cnt - rd0); fail_cnt++;
        end
        assert_cnt++;
        if (lows != 0) begin
            $display("FAIL empty_tx: low cycles %0d want 0", lows); fail_cnt++;
        end
        assert_cnt++;
        if (busys != 0) begin
            $display("FAIL empty_busy: busy cycles %0d want 0", busys); fail_cnt++;
        end
        enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [WL-1:0] w, e;
        logic p, g;
        int gp, rd0;
        rd0 = rd_cnt;
        fifo_write(8'd1);
        fifo_write(8'd10);
        fifo_write(8'd20);
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rx_frame(30, w, p, g, gp);
            e = exp_q.pop_front();
            assert_cnt++;
            if (!g || w !== e) begin
                $display("FAIL b2b_word%0d: got %h good %b want %h", k, w, g, e);
                fail_cnt++;
            end
            if (k > 0) begin
                assert_cnt++;
                if (gp != 3) begin
                    $display("FAIL b2b_gap%0d: got %0d want 3", k, gp);
                    fail_cnt++;
                end
            end
        end
        repeat (5) @(negedge clk);
        assert_cnt++;
        if (busy !== 1'b0 || rd_cnt - rd0 != 3) begin
            $display("FAIL b2b_end: busy %b reads %0d want 0 and 3",
                     busy, rd_cnt - rd0);
            fail_cnt++;
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        logic [WL-1:0] w, e;
        logic p, g;
        int gp, rd0;
        rd0 = rd_cnt;
        fifo_write(8'h2A);
        fifo_write(8'h55);
        enable = 1'b1;
        fork
            begin
                rx_frame(30, w, p, g, gp);
            end
            begin
                repeat (12) @(negedge clk);
                enable = 1'b0;
            end
        join
        e = exp_q.pop_front();
        assert_cnt++;
        if (!g || w !== e) begin
            $display("FAIL drop_word: got %h good %b want %h", w, g, e);
            fail_cnt++;
        end
        repeat (6) @(negedge clk);
        assert_cnt++;
        if (busy !== 1'b0) begin
            $display("FAIL drop_busy: got %b want 0", busy); fail_cnt++;
        end
        assert_cnt++;
        if (rd_cnt - rd0 != 1 || stack_empty !== 1'b0) begin
            $display("FAIL drop_reads: reads %0d empty %b want 1 and 0",
                     rd_cnt - rd0, stack_empty);
            fail_cnt++;
        end
        enable = 1'b1;
        rx_frame(30, w, p, g, gp);
        enable = 1'b0;
        e = exp_q.pop_front();
        assert_cnt++;
        if (!g || w !== e) begin
            $display("FAIL drop_drain: got %h good %b want %h", w, g, e);
            fail_cnt++;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [WL-1:0] w, e, lost;
        logic p, g;
        int gp;
        fifo_write(8'h77);
        enable = 1'b1;
        repeat (12) @(negedge clk);
        assert_cnt++;
        if (busy !== 1'b1) begin
            $display("FAIL midrst_pre: busy %b want 1", busy); fail_cnt++;
        end
        #1 rst_n = 1'b0;
        #1;
        assert_cnt++;
        if (tx_serial !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL midrst_async: tx %b busy %b want 1 0",
                     tx_serial, busy);
            fail_cnt++;
        end
        // The word read before the reset is discarded by the design.
        lost = exp_q.pop_front();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fifo_write(8'h1E);
        rx_frame(30, w, p, g, gp);
        e = exp_q.pop_front();
        assert_cnt++;
        if (!g || w !== e || w === lost) begin
            $display("FAIL midrst_frame: got %h good %b want %h", w, g, e);
            fail_cnt++;
        end
        enable = 1'b0;
        repeat (6) @(negedge clk);
    endtask

`ifdef TX_PARITY_EN
    task automatic test_parity();
        logic [WL-1:0] w, e;
        logic p, g;
        int gp;
        fifo_write(8'h03);
        fifo_write(8'h01);
        enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rx_frame(30, w, p, g, gp);
            e = exp_q.pop_front();
            assert_cnt++;
            if (!g || w !== e || p !== ^e) begin
                $display("FAIL parity%0d: got %h par %b want %h par %b",
                         k, w, p, e, ^e);
                fail_cnt++;
            end
        end
        enable = 1'b0;
        repeat (6) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_empty_idle();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_frame();
`ifdef TX_PARITY_EN
        test_parity();
`endif
        assert_cnt++;
        if (rd_empty != 0) begin
            $display("FAIL read_when_empty: got %0d want 0", rd_empty);
            fail_cnt++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_cnt, fail_cnt);
        $finish;
    end

endmodule
